// File: rtl/rvx_irq_arbiter_pkg.sv
//------------------------------------------------------------------------------
// rvx_irq_arbiter_pkg
// Shared constants for the external interrupt arbiter: register byte offsets,
// claim FSM state encodings, the maximum source count and an ID type.
// Ports: none (package).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rvx_irq_arbiter_pkg;

  localparam int RVX_IRQ_MAX_SOURCES = 31;

  localparam logic [4:0] RVX_IRQ_ARBITER_PENDING_ADDR = 5'h00;
  localparam logic [4:0] RVX_IRQ_ARBITER_ENABLE_ADDR  = 5'h04;
  localparam logic [4:0] RVX_IRQ_ARBITER_EDGE_ADDR    = 5'h08;
  localparam logic [4:0] RVX_IRQ_ARBITER_CLAIM_ADDR   = 5'h0C;
  localparam logic [4:0] RVX_IRQ_ARBITER_STATUS_ADDR  = 5'h10;

  localparam logic [0:0] RVX_IRQ_STATE_IDLE    = 1'b0;
  localparam logic [0:0] RVX_IRQ_STATE_CLAIMED = 1'b1;

  // Source ID: source i is ID i+1, ID 0 means "none".
  typedef logic [4:0] irq_id_t;

  // Register decode uses bits [4:2] only; the byte lane bits are ignored.
  function automatic logic [4:0] reg_offset(input logic [4:0] addr);
    return {addr[4:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rvx_irq_gateway.sv
//------------------------------------------------------------------------------
// rvx_irq_gateway
// Per-source interrupt gateway: optional 2-flop synchronizer (macro
// RVX_IRQ_ARBITER_SYNC_EN), edge history and the pending latch.
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   src              raw request line
//   edge_mode        1 = rising-edge capture, 0 = level capture
//   in_service       this source's ID is currently claimed
//   claim_clear      this source is being claimed this cycle
//   pending          latched request
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rvx_irq_gateway (
  input  logic clock,
  input  logic reset_n,
  input  logic src,
  input  logic edge_mode,
  input  logic in_service,
  input  logic claim_clear,
  output logic pending
);

  logic sampled;
  logic prev;
  logic set_req;

`ifdef RVX_IRQ_ARBITER_SYNC_EN
  logic sync_meta;
  logic sync_out;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= src;
      sync_out  <= sync_meta;
    end
  end

  assign sampled = sync_out;
`else
  assign sampled = src;
`endif

  // Edge mode may re-arm while in service; level mode waits until the
  // source is released from service so a held line is not claimed twice.
  assign set_req = edge_mode ? (sampled & ~prev) : (sampled & ~in_service);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev <= sampled;
      // A claim wins over a coincident set, so a level source held high is
      // not re-latched on the claim edge itself.
      if (claim_clear) begin
        pending <= 1'b0;
      end else if (set_req) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rvx_irq_arbiter.sv
//------------------------------------------------------------------------------
// rvx_irq_arbiter
// Shares the machine external interrupt among up to 31 sources. Fixed
// priority (lowest ID wins), claim/complete register pair with one claim
// outstanding. Optional input synchronizers: RVX_IRQ_ARBITER_SYNC_EN.
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   irq_sources      raw peripheral request lines
//   rw_address       register byte address ([4:2] decoded)
//   read_request     single-cycle read strobe
//   write_request    single-cycle write strobe
//   write_data       write payload
//   read_data        registered read result, held until next read
//   irq_external     registered interrupt request to the CSR file
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

import rvx_irq_arbiter_pkg::*;

module rvx_irq_arbiter #(
  parameter int NUM_SOURCES = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_SOURCES-1:0] irq_sources,
  input  logic [4:0]             rw_address,
  input  logic                   read_request,
  input  logic                   write_request,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   irq_external
);

  localparam int PAD = 32 - NUM_SOURCES;

  logic [NUM_SOURCES-1:0] enable_q;
  logic [NUM_SOURCES-1:0] edge_q;
  logic [NUM_SOURCES-1:0] pending;
  logic [NUM_SOURCES-1:0] claim_clear;
  logic [NUM_SOURCES-1:0] in_service;
  logic [0:0]             state_q;
  irq_id_t                id_q;

  logic                   win_valid;
  irq_id_t                win_id;
  logic [4:0]             offset;
  logic                   is_claim;
  logic                   claim_take;
  logic                   complete;
  logic [31:0]            rd_mux;
  logic                   unused_bits;

  assign unused_bits = ^write_data[31:NUM_SOURCES];

  // Scan from the top so the lowest enabled pending source is left last.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (pending[i] && enable_q[i]) begin
        win_valid = 1'b1;
        win_id    = 5'(i + 1);
      end
    end
  end

  assign offset     = reg_offset(rw_address);
  assign is_claim   = (offset == RVX_IRQ_ARBITER_CLAIM_ADDR);
  assign claim_take = read_request & is_claim & (state_q == RVX_IRQ_STATE_IDLE) & win_valid;
  assign complete   = write_request & is_claim & (state_q == RVX_IRQ_STATE_CLAIMED) &
                      (write_data[4:0] == id_q);

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    assign claim_clear[i] = claim_take & (win_id == 5'(i + 1));
    assign in_service[i]  = (state_q == RVX_IRQ_STATE_CLAIMED) & (id_q == 5'(i + 1));

    rvx_irq_gateway u_gateway (
      .clock      (clock),
      .reset_n    (reset_n),
      .src        (irq_sources[i]),
      .edge_mode  (edge_q[i]),
      .in_service (in_service[i]),
      .claim_clear(claim_clear[i]),
      .pending    (pending[i])
    );
  end

  // Read mux reflects pre-write state, so a same-cycle claim read and
  // complete write returns 0 and the claim only sees IDLE next cycle.
  always_comb begin
    rd_mux = '0;
    case (offset)
      RVX_IRQ_ARBITER_PENDING_ADDR: rd_mux = {{PAD{1'b0}}, pending};
      RVX_IRQ_ARBITER_ENABLE_ADDR:  rd_mux = {{PAD{1'b0}}, enable_q};
      RVX_IRQ_ARBITER_EDGE_ADDR:    rd_mux = {{PAD{1'b0}}, edge_q};
      RVX_IRQ_ARBITER_CLAIM_ADDR:   rd_mux = (state_q == RVX_IRQ_STATE_IDLE && win_valid) ?
                                             {27'd0, win_id} : 32'd0;
      RVX_IRQ_ARBITER_STATUS_ADDR:  rd_mux = {(state_q == RVX_IRQ_STATE_CLAIMED), 26'd0, id_q};
      default:                      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enable_q     <= '0;
      edge_q       <= '0;
      state_q      <= RVX_IRQ_STATE_IDLE;
      id_q         <= '0;
      read_data    <= '0;
      irq_external <= 1'b0;
    end else begin
      irq_external <= (state_q == RVX_IRQ_STATE_IDLE) & win_valid;

      if (read_request) begin
        read_data <= rd_mux;
      end

      if (write_request && offset == RVX_IRQ_ARBITER_ENABLE_ADDR) begin
        enable_q <= write_data[NUM_SOURCES-1:0];
      end
      if (write_request && offset == RVX_IRQ_ARBITER_EDGE_ADDR) begin
        edge_q <= write_data[NUM_SOURCES-1:0];
      end

      // claim_take requires IDLE and complete requires CLAIMED, so they
      // never fire together.
      if (complete) begin
        state_q <= RVX_IRQ_STATE_IDLE;
        id_q    <= '0;
      end else if (claim_take) begin
        state_q <= RVX_IRQ_STATE_CLAIMED;
        id_q    <= win_id;
      end
    end
  end

endmodule

`default_nettype wire
